spi_flash_rd_engine: RTL and testbench

//  SPI-flash READ (0x03) sequencer in the write clock domain, directly upstream of the

---
 rtl/spi_flash_pkg.sv | 19 +
 rtl/spi_clk_div.sv | 35 +++
 rtl/spi_flash_rd_engine.sv | 154 +++++++++++++++
 tb/tb_spi_flash_rd_engine.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI-flash READ sequencer: opcode default, FSM
// encoding and header/byte bit-count widths.
package spi_flash_pkg;

    localparam logic [7:0] CMD_RD_DEF = 8'h03;
    localparam int         HDR_BITS   = 32;
    localparam int         HDR_CNT_W  = $clog2(HDR_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CS_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period divider. Emits one tick every CLK_DIV enabled cycles, split
// into rise/fall according to the current SCK level.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic w_clk,
    input  logic w_rstn,
    input  logic en,
    input  logic clr,
    input  logic sck_lvl,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick      = en && !clr && (cnt == LAST);
    assign rise_tick = tick && !sck_lvl;
    assign fall_tick = tick && sck_lvl;

    // Restarting from zero after a clear gives a full half-period on resume.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_flash_rd_engine.sv
// SPI-flash READ (0x03) sequencer: shifts command + 24-bit address, reads len
// bytes and pushes each into the FIFO write side, stalling SCK while full.
module spi_flash_rd_engine
    import spi_flash_pkg::*;
#(
    parameter int          DATA_W  = 8,
    parameter int          LEN_W   = 16,
    parameter int          CLK_DIV = 2,
    parameter logic [7:0]  CMD_RD  = CMD_RD_DEF
) (
    input  logic              w_clk,
    input  logic              w_rstn,
    input  logic              start,
    input  logic [23:0]       addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] w_data,
    output logic              w_inc
);
    localparam int            BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    state_t                state;
    logic [30:0]           tx_sr;
    logic [DATA_W-2:0]     rx_sr;
    logic [DATA_W-1:0]     rx_next;
    logic [HDR_CNT_W-1:0]  hdr_cnt;
    logic [BW-1:0]         dat_cnt;
    logic [LEN_W-1:0]      len_cnt;
    logic                  pend;
    logic                  running;
    logic                  data_idle;
    logic                  rise_tick;
    logic                  fall_tick;

    assign rx_next = {rx_sr, spi_miso};
    assign w_inc   = pend && !fifo_full;
    assign running = (state == ST_CS_SETUP) || (state == ST_CMD) || (state == ST_ADDR) ||
                     (state == ST_DATA) || (state == ST_CS_HOLD);

    // At a byte boundary with SCK low: either a push is still pending or all bytes are in.
    assign data_idle = (state == ST_DATA) && !spi_sck && (dat_cnt == '0) &&
                       (pend || (len_cnt == '0));

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .w_clk    (w_clk),
        .w_rstn   (w_rstn),
        .en       (running),
        .clr      (!running || data_idle),
        .sck_lvl  (spi_sck),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            w_data   <= '0;
            pend     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            hdr_cnt  <= '0;
            dat_cnt  <= '0;
            len_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (w_inc) begin
                pend <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_CS_SETUP;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= CMD_RD[7];
                        tx_sr    <= {CMD_RD[6:0], addr};
                        len_cnt  <= len;
                        hdr_cnt  <= '0;
                        dat_cnt  <= '0;
                    end
                end
                ST_CS_SETUP: begin
                    if (rise_tick) begin
                        state <= ST_CMD;
                    end
                end
                ST_CMD, ST_ADDR: begin
                    if (rise_tick) begin
                        spi_sck <= 1'b1;
                        hdr_cnt <= hdr_cnt + 1'b1;
                        if (hdr_cnt == HDR_CNT_W'(7)) begin
                            state <= ST_ADDR;
                        end
                    end else if (fall_tick) begin
                        spi_sck <= 1'b0;
                        tx_sr   <= {tx_sr[29:0], 1'b0};
                        // hdr_cnt has wrapped to zero once all 32 header bits were clocked
                        if (hdr_cnt == '0) begin
                            spi_mosi <= 1'b0;
                            state    <= (len_cnt == '0) ? ST_CS_HOLD : ST_DATA;
                        end else begin
                            spi_mosi <= tx_sr[30];
                        end
                    end
                end
                ST_DATA: begin
                    if (rise_tick) begin
                        spi_sck <= 1'b1;
                        rx_sr   <= rx_next[DATA_W-2:0];
                        if (dat_cnt == BIT_LAST) begin
                            dat_cnt <= '0;
                            w_data  <= rx_next;
                            pend    <= 1'b1;
                            len_cnt <= len_cnt - 1'b1;
                        end else begin
                            dat_cnt <= dat_cnt + 1'b1;
                        end
                    end else if (fall_tick) begin
                        spi_sck <= 1'b0;
                    end else if (data_idle && !pend) begin
                        state <= ST_CS_HOLD;
                    end
                end
                ST_CS_HOLD: begin
                    if (rise_tick) begin
                        state    <= ST_DONE;
                        spi_cs_n <= 1'b1;
                        done     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_engine.sv
// Bench for spi_flash_rd_engine: table of directed reads, random reads with random
// FIFO back-pressure, and hand-written reset corner cases.
module tb_spi_flash_rd_engine;

    logic        w_clk = 1'b0;
    logic        w_rstn = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, spi_cs_n, spi_sck, spi_mosi, w_inc;
    logic        spi_miso = 1'b0;
    logic        fifo_full = 1'b0;
    logic [7:0]  w_data;

    always #5 w_clk = ~w_clk;

    spi_flash_rd_engine #(.DATA_W(8), .LEN_W(16), .CLK_DIV(2), .CMD_RD(8'h03)) dut (
        .w_clk    (w_clk),
        .w_rstn   (w_rstn),
        .start    (start),
        .addr     (addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .fifo_full(fifo_full),
        .w_data   (w_data),
        .w_inc    (w_inc)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Observer / flash slave / FIFO model state
    int          rises, falls, done_cnt, done_bad, win_bad, mosi_bad;
    logic [31:0] mosi_word;
    logic [7:0]  got[$];
    logic [7:0]  mdata[0:15];
    int          exp_len;
    int          full_rise, full_cycles, full_left;
    bit          full_armed, rand_full;
    logic [7:0]  wd_hold;
    logic        sck_q = 1'b0;

    always @(negedge w_clk) begin
        int         idx;
        logic [7:0] b;
        if (spi_sck && !sck_q) begin
            if (fifo_full && !rand_full) win_bad++;
            rises++;
            if (rises <= 32) mosi_word = {mosi_word[30:0], spi_mosi};
            else if (spi_mosi) mosi_bad++;
        end
        if (!spi_sck && sck_q) begin
            falls++;
            if (falls >= 32) begin
                idx = falls - 32;
                if (idx < exp_len * 8) begin
                    b = mdata[idx / 8];
                    spi_miso = b[3'(7 - (idx % 8))];
                end else begin
                    spi_miso = 1'b0;
                end
            end
        end
        sck_q = spi_sck;
        if (rand_full) begin
            fifo_full = ($urandom_range(0, 3) == 0);
        end else if (full_left > 0) begin
            full_left--;
            if (full_left == 0) fifo_full = 1'b0;
        end else if (full_armed && rises == full_rise) begin
            full_armed = 1'b0;
            fifo_full  = 1'b1;
            full_left  = full_cycles;
            wd_hold    = w_data;
        end
        #1;
        if (fifo_full && !rand_full) begin
            if (w_inc) win_bad++;
            if (w_data !== wd_hold) win_bad++;
            if (spi_cs_n) win_bad++;
        end
        if (w_inc) got.push_back(w_data);
        if (done) begin
            done_cnt++;
            if (!spi_cs_n) done_bad++;
            if (got.size() != exp_len) done_bad++;
        end
    end

    task automatic clear_obs(input int n, input int frise, input int fcyc, input bit rnd);
        rises = 0; falls = 0; done_cnt = 0; done_bad = 0; win_bad = 0; mosi_bad = 0;
        mosi_word = '0;
        got.delete();
        exp_len = n; full_rise = frise; full_cycles = fcyc; full_left = 0;
        full_armed = (frise != 0); rand_full = rnd;
    endtask

    task automatic run_txn(input string tag, input logic [23:0] a, input int n, input int frise,
                           input int fcyc, input bit rnd, input bit inj, input int exp_rises);
        int cyc;
        @(posedge w_clk);
        clear_obs(n, frise, fcyc, rnd);
        @(negedge w_clk);
        addr = a; len = 16'(n); start = 1'b1;
        @(negedge w_clk);
        start = 1'b0;
        chk({tag, " busy_after_start"}, busy, 1);
        if (inj) begin
            repeat (30) @(negedge w_clk);
            start = 1'b1; addr = 24'hFFFFFF; len = 16'd7;
            @(negedge w_clk);
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            @(negedge w_clk);
            cyc++;
        end
        chk({tag, " done_seen"}, (done_cnt > 0), 1);
        repeat (12) @(negedge w_clk);
        #3;
        rand_full = 1'b0; fifo_full = 1'b0;
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_ctx"}, done_bad, 0);
        chk({tag, " sck_rises"}, rises, exp_rises);
        chk({tag, " sck_falls"}, falls, exp_rises);
        chk({tag, " mosi_hdr"}, mosi_word, {8'h03, a});
        chk({tag, " mosi_data_zero"}, mosi_bad, 0);
        chk({tag, " stall_window"}, win_bad, 0);
        chk({tag, " push_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s byte%0d", tag, i), (got.size() > i) ? longint'(got[i]) : -1,
                mdata[i]);
        end
        chk({tag, " idle_busy"}, busy, 0);
        chk({tag, " idle_cs_n"}, spi_cs_n, 1);
    endtask

    typedef struct {
        logic [23:0] a;
        int          n;
        logic [31:0] d;
        int          frise;
        int          fcyc;
        bit          inj;
        int          exp_rises;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          cyc;
        int          n;
        logic [23:0] a;

        vecs[0] = '{24'h123456, 2, 32'hA53C0000,  0,  0, 1'b0, 48};
        vecs[1] = '{24'h123456, 2, 32'hA53C0000, 40, 20, 1'b0, 48};
        vecs[2] = '{24'hABCDEF, 0, 32'h00000000,  0,  0, 1'b1, 32};
        vecs[3] = '{24'h0F1E2D, 3, 32'h11223300, 56,  5, 1'b0, 56};
        vecs[4] = '{24'h000000, 1, 32'hFF000000,  0,  0, 1'b0, 40};
        vecs[5] = '{24'hFFFFFF, 4, 32'h0080017E, 48,  3, 1'b0, 64};
        clear_obs(0, 0, 0, 1'b0);

        // Reset state
        #12;
        chk("rst cs_n", spi_cs_n, 1);
        chk("rst sck", spi_sck, 0);
        chk("rst mosi", spi_mosi, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst w_inc", w_inc, 0);
        chk("rst w_data", w_data, 0);
        @(negedge w_clk);
        w_rstn = 1'b1;
        repeat (6) @(negedge w_clk);
        chk("idle cs_n", spi_cs_n, 1);
        chk("idle sck", spi_sck, 0);
        chk("idle busy", busy, 0);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) mdata[i] = vecs[v].d[31 - 8*i -: 8];
            run_txn($sformatf("vec%0d", v), vecs[v].a, vecs[v].n, vecs[v].frise, vecs[v].fcyc,
                    1'b0, vecs[v].inj, vecs[v].exp_rises);
        end

        // Async reset during data byte 1, with SCK high
        mdata[0] = 8'hC3; mdata[1] = 8'h5A;
        @(posedge w_clk);
        clear_obs(2, 0, 0, 1'b0);
        @(negedge w_clk);
        addr = 24'h00ABCD; len = 16'd2; start = 1'b1;
        @(negedge w_clk);
        start = 1'b0;
        cyc = 0;
        while (!(rises >= 34 && spi_sck) && cyc < 1000) begin
            @(negedge w_clk);
            cyc++;
        end
        chk("arst reached_data", (rises >= 34 && spi_sck), 1);
        #2 w_rstn = 1'b0;
        #1;
        chk("arst cs_n", spi_cs_n, 1);
        chk("arst sck", spi_sck, 0);
        chk("arst busy", busy, 0);
        repeat (3) @(negedge w_clk);
        w_rstn = 1'b1;
        got.delete();
        repeat (40) @(negedge w_clk);
        chk("arst no_push", got.size(), 0);
        chk("arst cs_idle", spi_cs_n, 1);
        run_txn("arst_rerun", 24'h00ABCD, 2, 0, 0, 1'b0, 1'b0, 48);

        // Random reads against the spec-level model with random FIFO back-pressure
        for (int r = 0; r < 8; r++) begin
            a = 24'($urandom);
            n = $urandom_range(0, 5);
            for (int i = 0; i < 16; i++) mdata[i] = 8'($urandom);
            run_txn($sformatf("rnd%0d", r), a, n, 0, 0, 1'b1, 1'b0, 32 + 8 * n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
